ysyx_25050141_stage_buf: RTL and testbench
==========================================

# ysyx_25050141_stage_buf

Parametrised inter-stage pipeline buffer that carries one stage-to-stage bus (IF→DE, DE→EX, EX→ME, ME→DE) with a valid/ready handshake, a DEPTH-entry FIFO and a synchronous flush. It replaces the direct wire connection between stages so the core can stall a downstream stage and squash in-flight work on redirect. One instance per inter-stage bus; WIDTH is set to that bus's `*_WIDTH` macro.

## Interface
- WIDTH, 32, bit width of the carried bus (≥1)
- DEPTH, 2, number of buffered entries (legal 1..8, need not be a power of two)
- CW, $clog2(DEPTH+1), width of the count output (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash of all buffered entries
- in_valid  in  1  producer stage presents a bus word
- in_ready  out  1  buffer accepts a word this cycle
- in_bus  in  WIDTH  producer bus word
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer stage takes the head this cycle
- out_bus  out  WIDTH  head entry data
- count  out  CW  number of valid entries (0..DEPTH)

## Operation
- Storage: DEPTH×WIDTH register array, read pointer rp, write pointer wp, occupancy cnt; pointers wrap from DEPTH-1 to 0 explicitly (no power-of-two masking).
- enq = in_valid & in_ready; deq = out_valid & out_ready.
- in_ready = (cnt != DEPTH) & ~flush. No pass-through when full: a dequeue in the same cycle does not make room for that cycle's enqueue.
- out_valid = (cnt != 0); out_bus = mem[rp] (combinational read of registered storage); count = cnt.
- Per rising edge, priority order:
  - flush=1: cnt←0, rp←0, wp←0; any in_valid that cycle is dropped (in_ready already 0); out_ready that cycle is ignored for state (entry discarded anyway). Storage contents not cleared.
  - else enq only: mem[wp]←in_bus, wp←wp+1 (wrap), cnt←cnt+1.
  - else deq only: rp←rp+1 (wrap), cnt←cnt-1.
  - else enq & deq: both pointer updates, cnt unchanged, write and read target different slots except when cnt==0 (cannot occur: deq needs cnt≥1).
  - else hold.
- out_bus is don't-care when out_valid=0; bench must not check it then (except after reset, below).
- in_bus sampled only on enq; out_valid/out_bus stay stable until deq or flush (no retraction).

## Timing
- Reset (async assert, sync release irrelevant to block): cnt=0, rp=0, wp=0, all mem entries=0 → out_valid=0, out_bus=0, count=0, in_ready=1 (if flush=0).
- Reset asserted mid-operation clears state immediately, without waiting for clk; buffered data lost.
- Latency: word accepted at edge N is visible on out_bus with out_valid=1 in the cycle after edge N (1-cycle latency, no bypass).
- Throughput: DEPTH≥2 sustains 1 word/cycle with out_ready held high; DEPTH=1 sustains 1 word per 2 cycles (in_ready low while the single entry is occupied).
- in_ready depends combinationally only on cnt and flush, never on out_ready; out_valid depends only on cnt. No combinational path in_valid→out_valid or out_ready→in_ready.
- Flush takes effect at the edge where it is sampled: the following cycle shows count=0, out_valid=0, in_ready=1.

## Test plan
- Reset: drive rst=1 asynchronously mid-cycle with 2 entries held → out_valid=0, count=0, in_ready=1, out_bus=0 before next edge.
- Fill/drain, WIDTH=32 DEPTH=3, out_ready=0: push 0xA1,0xA2,0xA3 → count=3, in_ready=0, 4th push 0xA4 not accepted; then out_ready=1 → outputs 0xA1,0xA2,0xA3 in order on consecutive cycles, count back to 0.
- Streaming, DEPTH=2, in_valid and out_ready held high, data 1..10 → out_bus 1..10 one per cycle after 1-cycle latency, count stays 1; same with DEPTH=1 → one word every 2 cycles, no loss.
- Wrap-around, DEPTH=3: 20 words with random out_ready back-pressure (~50%) → output sequence equals input sequence, count never exceeds 3.
- Flush: 2 entries held, flush=1 with in_valid=1 in_bus=0x55 and out_ready=1 → next cycle count=0, out_valid=0; 0x55 never emerges; subsequent push 0x66 appears next cycle.
- Simultaneous enq/deq at count=1, DEPTH=2: push 0x77 while popping head 0x70 → count stays 1, next out_bus=0x77.

Source files
------------

// File: rtl/ysyx_25050141_stage_buf.sv
// Inter-stage pipeline buffer: DEPTH-entry FIFO with a valid/ready handshake
// on both sides and a synchronous flush that squashes every buffered word.
module ysyx_25050141_stage_buf #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bus,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rp, wp;
  logic [CW-1:0]    cnt;
  logic             enq, deq;

  // Ready looks only at occupancy and flush, so a same-cycle dequeue never
  // frees a slot for the same cycle's enqueue and out_ready cannot reach in_ready.
  assign in_ready  = (cnt != CW'(DEPTH)) & ~flush;
  assign out_valid = (cnt != '0);
  assign out_bus   = mem[rp];
  assign count     = cnt;

  assign enq = in_valid & in_ready;
  assign deq = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
      // NOTE: the storage array is reset too, because out_bus must read zero
      // straight after reset even though out_valid is low.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (enq) begin
        mem[wp] <= in_bus;
        wp      <= (wp == LAST) ? '0 : wp + PW'(1);
      end
      if (deq) rp <= (rp == LAST) ? '0 : rp + PW'(1);
      case ({enq, deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25050141_stage_buf.sv
// Self-checking bench: three buffer instances (DEPTH 1, 2, 3) exercised one at
// a time against a queue scoreboard that predicts handshake, count and data.
module tb_ysyx_25050141_stage_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        fl  [1:3];
  logic        iv  [1:3];
  logic        orr [1:3];
  logic [31:0] ib  [1:3];
  logic        ir  [1:3];
  logic        ov  [1:3];
  logic [31:0] ob  [1:3];
  logic        c1;
  logic [1:0]  c2, c3;

  int          checks = 0;
  int          errors = 0;
  int          cur;
  logic [31:0] sb [$];

  logic        s_ir, s_ov;
  logic [31:0] s_ob, s_cnt;

  always #5 clk = ~clk;

  ysyx_25050141_stage_buf #(.WIDTH(32), .DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_bus(ib[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_bus(ob[1]), .count(c1));
  ysyx_25050141_stage_buf #(.WIDTH(32), .DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_bus(ib[2]), .out_valid(ov[2]), .out_ready(orr[2]), .out_bus(ob[2]), .count(c2));
  ysyx_25050141_stage_buf #(.WIDTH(32), .DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .flush(fl[3]), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_bus(ib[3]), .out_valid(ov[3]), .out_ready(orr[3]), .out_bus(ob[3]), .count(c3));

  always_comb begin
    s_ir  = 1'b0;
    s_ov  = 1'b0;
    s_ob  = '0;
    s_cnt = '0;
    case (cur)
      1: begin s_ir = ir[1]; s_ov = ov[1]; s_ob = ob[1]; s_cnt = 32'(c1); end
      2: begin s_ir = ir[2]; s_ov = ov[2]; s_ob = ob[2]; s_cnt = 32'(c2); end
      3: begin s_ir = ir[3]; s_ov = ov[3]; s_ob = ob[3]; s_cnt = 32'(c3); end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut=%0d observed=%h expected=%h", tag, cur, obs, exp);
    end
  endtask

  // One clock cycle: compare DUT against the model mid-cycle, advance the model
  // with the handshake it predicts, then return just after the rising edge.
  task automatic step(output bit acc);
    int  mc;
    bit  en, de;
    @(negedge clk);
    mc = sb.size();
    check("in_ready",  32'(s_ir), 32'((mc != cur) && !fl[cur]));
    check("out_valid", 32'(s_ov), 32'(mc != 0));
    check("count",     s_cnt, 32'(mc));
    if (mc != 0) check("out_bus", s_ob, sb[0]);
    en  = iv[cur] && (mc != cur) && !fl[cur];
    de  = (mc != 0) && orr[cur];
    acc = en;
    if (fl[cur]) sb.delete();
    else begin
      if (de) void'(sb.pop_front());
      if (en) sb.push_back(ib[cur]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fl[cur] = 1'b0; iv[cur] = 1'b0; orr[cur] = 1'b0; ib[cur] = '0;
  endtask

  task automatic drain();
    bit a;
    iv[cur] = 1'b0; orr[cur] = 1'b1;
    for (int k = 0; k < 12 && sb.size() != 0; k++) step(a);
    step(a);
    check("drained", 32'(sb.size()), 32'd0);
    idle_inputs();
  endtask

  task automatic push(input logic [31:0] d);
    bit a;
    iv[cur] = 1'b1; ib[cur] = d;
    step(a);
    iv[cur] = 1'b0;
  endtask

  initial begin
    bit a;
    int sent, cyc;
    for (int i = 1; i <= 3; i++) begin
      fl[i] = 1'b0; iv[i] = 1'b0; orr[i] = 1'b0; ib[i] = '0;
    end
    cur = 1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 1; i <= 3; i++) begin
      cur = i;
      #1;
      check("rst_out_valid", 32'(s_ov), 32'd0);
      check("rst_count",     s_cnt,     32'd0);
      check("rst_in_ready",  32'(s_ir), 32'd1);
      check("rst_out_bus",   s_ob,      32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Fill and drain on DEPTH=3; the fourth push must be refused.
    cur = 3;
    push(32'hA1); push(32'hA2); push(32'hA3); push(32'hA4);
    step(a);
    check("full_count", s_cnt, 32'd3);
    drain();

    // Streaming: data advances only when the model says the word was taken.
    for (int d = 2; d >= 1; d--) begin
      cur = d; sent = 1;
      iv[cur] = 1'b1; orr[cur] = 1'b1;
      for (cyc = 0; cyc < 40 && sent <= 10; cyc++) begin
        ib[cur] = 32'(sent);
        step(a);
        if (a) sent++;
      end
      check("stream_sent", 32'(sent), 32'd11);
      check("stream_cycles", 32'(cyc), (d == 2) ? 32'd10 : 32'd19);
      drain();
    end

    // Wrap-around with random back-pressure on DEPTH=3.
    cur = 3; sent = 0;
    for (cyc = 0; cyc < 500 && (sent < 20 || sb.size() != 0); cyc++) begin
      iv[cur]  = (sent < 20);
      ib[cur]  = 32'h100 + 32'(sent);
      orr[cur] = 1'($urandom_range(0, 1));
      step(a);
      if (a) sent++;
    end
    check("wrap_complete", 32'((sent == 20) && (sb.size() == 0)), 32'd1);
    drain();

    // Asynchronous reset mid-cycle with two entries held.
    push(32'hB1); push(32'hB2);
    #3 rst = 1'b1;
    #1;
    check("async_out_valid", 32'(s_ov), 32'd0);
    check("async_count",     s_cnt,     32'd0);
    check("async_in_ready",  32'(s_ir), 32'd1);
    check("async_out_bus",   s_ob,      32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    // Flush on DEPTH=2 while a push and a pop are both attempted.
    cur = 2;
    push(32'h10); push(32'h11);
    fl[cur] = 1'b1; iv[cur] = 1'b1; ib[cur] = 32'h55; orr[cur] = 1'b1;
    step(a);
    idle_inputs();
    step(a);
    check("flush_count", s_cnt, 32'd0);
    push(32'h66);
    step(a);
    check("post_flush_head", s_ob, 32'h66);
    drain();

    // Simultaneous enqueue and dequeue at count=1.
    push(32'h70);
    iv[cur] = 1'b1; ib[cur] = 32'h77; orr[cur] = 1'b1;
    step(a);
    idle_inputs();
    step(a);
    check("simul_count", s_cnt, 32'd1);
    check("simul_head",  s_ob,  32'h77);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
